// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport
// Purpose  : Parametrised integer register file for the decode/execute
//            boundary. It has one write port and NUM_READ read ports, plus an
//            optional hard-wired zero register and write-to-read bypass. Read
//            data can be combinational or registered. A clear sweep zeroes one
//            entry per cycle without using reset.
// Ports    : clock        - rising-edge clock
//            reset_n      - asynchronous reset, active low
//            write_enable - write strobe
//            rd           - write address
//            result       - write data
//            rs           - packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//            rdata        - packed read data, port i at [i*XLEN +: XLEN]
//            clear        - pulse that starts a clear sweep
//            busy         - high while the clear sweep runs
// Revision : 1.0 - initial release
// ============================================================================
module regfile_multiport #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit REG_READ = 1'b1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       write_enable,
  input  logic [ADDR_W-1:0]          rd,
  input  logic [XLEN-1:0]            result,
  input  logic [NUM_READ*ADDR_W-1:0] rs,
  output logic [NUM_READ*XLEN-1:0]   rdata,
  input  logic                       clear,
  output logic                       busy
);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_clear = 1'b1;

  // DEPTH need not be a power of two, so address range checks compare
  // against DEPTH with one extra bit of headroom.
  localparam logic [ADDR_W:0]   c_depth_ext = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [XLEN-1:0]   mem_d [DEPTH];

  logic                     w_wr_ok;
  logic [NUM_READ*XLEN-1:0] w_rd_val;

  assign busy = (state_q == c_st_clear);

  // Writes are only honoured while idle. Out-of-range addresses and the
  // zero register are dropped without any indication.
  assign w_wr_ok = write_enable && (state_q == c_st_idle)
                && ({1'b0, rd} < c_depth_ext)
                && !(ZERO_REG && (rd == '0));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    if (state_q == c_st_idle) begin
      // A write that coincides with clear still lands. The sweep that
      // starts next cycle erases it.
      if (w_wr_ok) begin
        mem_d[rd] = result;
      end
      if (clear) begin
        state_d = c_st_clear;
        idx_d   = '0;
      end
    end else begin
      mem_d[idx_q] = '0;
      if (idx_q == c_last_idx) begin
        state_d = c_st_idle;
      end else begin
        idx_d = idx_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_st_idle;
      idx_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
    end
  end

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read_port
    logic [ADDR_W-1:0] w_rs;
    logic [XLEN-1:0]   w_val;

    assign w_rs = rs[gi*ADDR_W +: ADDR_W];

    always_comb begin
      w_val = mem_q[w_rs];
      if (BYPASS && w_wr_ok && (rd == w_rs)) begin
        w_val = result;
      end
      // Forced-zero cases take priority over both storage and bypass.
      if (({1'b0, w_rs} >= c_depth_ext) || (ZERO_REG && (w_rs == '0)) || busy) begin
        w_val = '0;
      end
    end

    assign w_rd_val[gi*XLEN +: XLEN] = w_val;
  end

  if (REG_READ) begin : g_reg_read
    logic [NUM_READ*XLEN-1:0] rdata_q, rdata_d;

    assign rdata_d = w_rd_val;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata = rdata_q;
  end else begin : g_comb_read
    assign rdata = w_rd_val;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_multiport
// Purpose  : Self-checking bench for regfile_multiport. It builds two
//            configurations that share one stimulus:
//              A: DEPTH=32, zero reg, bypass, registered read
//              B: DEPTH=20, no zero reg, no bypass, combinational read
//            Each configuration is compared against an array-based
//            reference model on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_multiport;

  localparam int XLEN = 32;
  localparam int NR   = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             we;
  logic             clr;
  logic [AW-1:0]    rd;
  logic [XLEN-1:0]  res;
  logic [NR*AW-1:0] rs;
  logic [NR*XLEN-1:0] rdata_a, rdata_b;
  logic             busy_a, busy_b;

  regfile_multiport #(
    .XLEN(32), .DEPTH(32), .NUM_READ(2),
    .ZERO_REG(1'b1), .BYPASS(1'b1), .REG_READ(1'b1)
  ) u_dut_a (
    .clock(clk), .reset_n(rst_n), .write_enable(we), .rd(rd), .result(res),
    .rs(rs), .rdata(rdata_a), .clear(clr), .busy(busy_a)
  );

  regfile_multiport #(
    .XLEN(32), .DEPTH(20), .NUM_READ(2),
    .ZERO_REG(1'b0), .BYPASS(1'b0), .REG_READ(1'b0)
  ) u_dut_b (
    .clock(clk), .reset_n(rst_n), .write_enable(we), .rd(rd), .result(res),
    .rs(rs), .rdata(rdata_b), .clear(clr), .busy(busy_b)
  );

  // ---------------- reference model ----------------
  int          depth [2] = '{32, 20};
  bit          zr    [2] = '{1'b1, 1'b0};
  bit          byp   [2] = '{1'b1, 1'b0};
  bit          rr    [2] = '{1'b1, 1'b0};
  logic [31:0] m     [2][32];
  logic [31:0] rreg  [2][2];
  int          sweep_left [2];

  int checks = 0;
  int errors = 0;

  function automatic bit wr_ok(int d);
    return we && (sweep_left[d] == 0) && (int'(rd) < depth[d]) && !(zr[d] && rd == 0);
  endfunction

  function automatic int rs_of(int p);
    return int'(rs[p*AW +: AW]);
  endfunction

  function automatic logic [31:0] read_val(int d, int a);
    if (a >= depth[d] || (zr[d] && a == 0) || sweep_left[d] > 0) return 32'h0;
    if (byp[d] && wr_ok(d) && int'(rd) == a) return res;
    return m[d][a];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      sweep_left[d] = 0;
      for (int a = 0; a < 32; a++) m[d][a] = 32'h0;
      for (int p = 0; p < NR; p++) rreg[d][p] = 32'h0;
    end
  endtask

  // One rising edge. All read values and write legality are taken from the
  // state before the edge.
  task automatic model_edge();
    logic [31:0] nv [2][2];
    bit          ok [2];
    for (int d = 0; d < 2; d++) begin
      ok[d] = wr_ok(d);
      for (int p = 0; p < NR; p++) nv[d][p] = read_val(d, rs_of(p));
    end
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NR; p++) rreg[d][p] = nv[d][p];
      if (sweep_left[d] > 0) begin
        m[d][depth[d] - sweep_left[d]] = 32'h0;
        sweep_left[d]--;
      end else begin
        if (ok[d]) m[d][rd] = res;
        if (clr) sweep_left[d] = depth[d];
      end
    end
  endtask

  // ---------------- check helpers ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply(bit w, int a, logic [31:0] d, int r0, int r1, bit c);
    we  = w;
    rd  = AW'(a);
    res = d;
    rs  = {AW'(r1), AW'(r0)};
    clr = c;
  endtask

  task automatic check_cycle();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NR; p++) begin
        logic [31:0] got, exp;
        got = (d == 0) ? rdata_a[p*XLEN +: XLEN] : rdata_b[p*XLEN +: XLEN];
        exp = rr[d] ? rreg[d][p] : read_val(d, rs_of(p));
        chk($sformatf("model rdata dut%0d port%0d t=%0t", d, p, $time), got, exp);
      end
    end
    chk("model busy dut0", 32'(busy_a), 32'(sweep_left[0] > 0));
    chk("model busy dut1", 32'(busy_b), 32'(sweep_left[1] > 0));
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          we;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [4:0]  rs0;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_a;
    int cnt_b;

    // A has a one-cycle read latency, so exp_a reflects the previous row's rs0.
    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  32'h0,        32'h0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 5'd0,  32'h12345678, 5'd0,  32'hDEADBEEF, 32'h0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  32'h0,        32'h12345678};
    tbl[5]  = '{1'b1, 5'd7,  32'h00000001, 5'd7,  32'h0,        32'h0};
    tbl[6]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  32'h00000001, 32'h00000001};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        5'd25, 32'hA5A5A5A5, 32'h0};
    tbl[9]  = '{1'b1, 5'd25, 32'hCAFEF00D, 5'd25, 32'h0,        32'h0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        5'd25, 32'hCAFEF00D, 32'h0};

    // T1: reset
    rst_n = 1'b0;
    apply(1'b0, 0, 32'h0, 0, 0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy dut0", 32'(busy_a), 32'h0);
    chk("reset busy dut1", 32'(busy_b), 32'h0);
    chk("reset rdata dut0", rdata_a[31:0], 32'h0);
    chk("reset rdata dut1", rdata_b[31:0], 32'h0);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      apply(1'b0, 0, 32'h0, a, 31 - a, 1'b0);
      check_cycle();
      advance();
    end

    // T2..T4 and out-of-range accesses
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].we, int'(tbl[i].rd), tbl[i].res, int'(tbl[i].rs0), int'(tbl[i].rs0), 1'b0);
      check_cycle();
      chk($sformatf("vec%0d dut0 port0", i), rdata_a[31:0], tbl[i].exp_a);
      chk($sformatf("vec%0d dut1 port0", i), rdata_b[31:0], tbl[i].exp_b);
      chk($sformatf("vec%0d dut0 port1", i), rdata_a[63:32], tbl[i].exp_a);
      advance();
    end

    // T5: fill, sweep, dropped writes, ignored second clear
    for (int i = 1; i < 32; i++) begin
      apply(1'b1, i, 32'(i), i, 0, 1'b0);
      check_cycle();
      advance();
    end
    apply(1'b0, 0, 32'h0, 1, 2, 1'b1);
    check_cycle();
    advance();
    cnt_a = 0;
    cnt_b = 0;
    for (int k = 0; k < 40; k++) begin
      apply(k < 30, 3, 32'hBAD00000 | 32'(k), int'($urandom_range(0, 31)), 3, k == 10);
      check_cycle();
      cnt_a += int'(busy_a);
      cnt_b += int'(busy_b);
      advance();
    end
    chk("sweep busy cycles dut0", 32'(cnt_a), 32'd32);
    chk("sweep busy cycles dut1", 32'(cnt_b), 32'd20);
    for (int i = 0; i <= 32; i++) begin
      apply(1'b0, 0, 32'h0, (i < 32) ? i : 0, 0, 1'b0);
      check_cycle();
      if (i > 0) chk($sformatf("post-sweep r%0d dut0", i - 1), rdata_a[31:0], 32'h0);
      advance();
    end

    // Randomized traffic; clear is held off near the end so no sweep is left running.
    for (int k = 0; k < 400; k++) begin
      apply(bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            (k < 360) && ($urandom_range(0, 49) == 0));
      check_cycle();
      advance();
    end

    // T6: reset seven cycles into a sweep
    apply(1'b0, 0, 32'h0, 25, 25, 1'b1);
    check_cycle();
    advance();
    for (int k = 0; k < 7; k++) begin
      apply(1'b1, 9, 32'h55AA55AA, 25, 9, 1'b0);
      check_cycle();
      advance();
    end
    chk("mid-sweep busy dut1", 32'(busy_b), 32'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async reset busy dut0", 32'(busy_a), 32'h0);
    chk("async reset busy dut1", 32'(busy_b), 32'h0);
    chk("async reset rdata dut0", rdata_a[31:0], 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(1'b0, 0, 32'h0, 25, 25, 1'b0);
    check_cycle();
    chk("rs=25 after reset dut1", rdata_b[31:0], 32'h0);
    advance();
    for (int a = 0; a < 32; a++) begin
      apply(1'b0, 0, 32'h0, a, 31 - a, 1'b0);
      check_cycle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
